// File: rtl/serial_adder.sv
// Bit-serial NUM_BITS-wide adder: one adder_1bit cell, one bit pair per cycle, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port for a-b via inverted B and forced carry.

module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out,
    output logic                overflow
);
    localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d;
    logic [NUM_BITS-1:0] sum_q, sum_d;
    logic                c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                fa_s, fa_co, load, sub_eff;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    adder_1bit u_fa (
        .a        (a_sh_q[0]),
        .b        (b_sh_q[0]),
        .carry_in (c_q),
        .sum      (fa_s),
        .carry_out(fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        case (state_q)
            IDLE: load = start;
            ADD: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {fa_s, res_q[NUM_BITS-1:1]};
                c_d    = fa_co;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = {fa_s, res_q[NUM_BITS-1:1]};
                    cout_d  = fa_co;
                    // c_q is still the carry into the MSB here
                    ovf_d   = c_q ^ fa_co;
                end
            end
            DONE: begin
                state_d = IDLE;
                load    = start;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = ADD;
            a_sh_d  = a;
            b_sh_d  = sub_eff ? ~b : b;
            c_d     = sub_eff ? 1'b1 : carry_in;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == ADD);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: per-cycle compare against a cycle-count/arithmetic model,
// plus literal expectations for the hand-computed vectors.

module tb_serial_adder;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0, b = '0;
    logic         carry_in = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, carry_out, overflow;
    logic [N-1:0] sum;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    serial_adder #(.NUM_BITS(N)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry_out(carry_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Model: edge count since reset, accept edge of the current op, its arithmetic result
    int           cyc = 0;
    int           e = 0;
    bit           act = 1'b0;
    logic [N:0]   m_res = '0;
    logic         m_ovr = 1'b0;
    logic [N-1:0] m_sum = '0;
    logic         m_co = 1'b0, m_ov = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cyc <= 0; act <= 1'b0; m_sum <= '0; m_co <= 1'b0; m_ov <= 1'b0;
        end else begin
            logic [N-1:0] bb;
            logic         ci;
            logic [N:0]   r;
            cyc <= cyc + 1;
            if (act && (cyc + 1 == e + N)) begin
                m_sum <= m_res[N-1:0];
                m_co  <= m_res[N];
                m_ov  <= m_ovr;
            end
            if (!(act && cyc >= e && cyc < e + N) && start) begin
`ifdef SERIAL_ADDER_SUB_EN
                bb = sub ? ~b : b;
                ci = sub ? 1'b1 : carry_in;
`else
                bb = b;
                ci = carry_in;
`endif
                r = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, ci};
                e     <= cyc + 1;
                act   <= 1'b1;
                m_res <= r;
                m_ovr <= (a[N-1] == bb[N-1]) && (r[N-1] != a[N-1]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 32'(busy), 32'(act && cyc >= e && cyc < e + N));
            chk("cyc_done", 32'(done), 32'(act && cyc == e + N));
            chk("cyc_sum",  32'(sum),  32'(m_sum));
            chk("cyc_cout", 32'(carry_out), 32'(m_co));
            chk("cyc_ovf",  32'(overflow),  32'(m_ov));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one op, wait (bounded) for done, check latency and literal results
    task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic,
                          input logic isub, input logic [N-1:0] es, input logic eco, input logic eov,
                          input bit scramble);
        int k;
        a = ia; b = ib; carry_in = ic; sub = isub; start = 1'b1;
        tick();
        start = 1'b0;
        if (scramble) begin a = '1; b = '1; carry_in = 1'b1; end
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (done) break;
        end
        chk("lat_cycles", 32'(k), 32'(N + 1));
        chk("op_sum",  32'(sum),       32'(es));
        chk("op_cout", 32'(carry_out), 32'(eco));
        chk("op_ovf",  32'(overflow),  32'(eov));
        tick();
    endtask

    initial begin
        int dn;
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk_en = 1'b1;
        tick();

        run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0);

        // Back-to-back with start held: done at 9, 18, 27 of 30 cycles
        a = 8'h00; b = 8'h00; carry_in = 1'b1; start = 1'b1;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("b2b_dones", 32'(dn), 32'd3);
        chk("b2b_sum", 32'(sum), 32'h01);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        tick();

        // Reset in the 4th ADD cycle
        a = 8'hAA; b = 8'h55; carry_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        n_rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum",  32'(sum),  32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        n_rst = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_nodone", 32'(dn), 32'd0);
        tick();
        run_op(8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);

        // Inputs change mid-ADD; result must reflect captured operands and then hold
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        repeat (5) tick();
        @(negedge clk);
        chk("hold_sum", 32'(sum), 32'h46);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
`endif
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one instance of the team's adder_1bit cell.
- Captures two operands on a start pulse and presents one bit pair per cycle, LSB first, to adder_1bit.
- Registers adder_1bit carry_out as the next cycle's carry_in and shifts sum bits into a result register.
- Sits between the operand source and the result consumer; replaces a ripple adder where area matters more than latency.

Parameters:
NUM_BITS, 8, operand/result width; legal range 2..32

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE state
a  input  NUM_BITS  operand A, captured on accepted start
b  input  NUM_BITS  operand B, captured on accepted start
carry_in  input  1  initial carry, captured on accepted start
busy  output  1  high while in ADD state
done  output  1  one-cycle completion pulse
sum  output  NUM_BITS  registered result, held until next completion
carry_out  output  1  final carry, held with sum
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB, held with sum

Behaviour:
- Reset (n_rst low, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0.
  - Shift registers, carry register and bit counter cleared.
- Reset mid-operation aborts immediately; no done pulse follows.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 at a rising edge: load a, b into shift registers, carry register=carry_in, counter=0, go to ADD.
  - start=0: remain in IDLE.
- ADD:
  - Each edge applies shiftA[0], shiftB[0] and the carry register to adder_1bit.
  - Shifts the sum bit into the result shift register MSB side, shifts operands right, loads carry register with carry_out, and increments the counter.
  - At the edge processing bit NUM_BITS-1, also latch the carry into the MSB (pre-update carry register) for overflow; go to DONE.
  - start ignored while in ADD; operand inputs may change freely.
- DONE:
  - done=1 for exactly this one cycle; sum, carry_out, overflow updated at the transition into DONE and valid while done=1.
  - Next edge: start=1 behaves exactly as start in IDLE (back-to-back accepted, goes to ADD); otherwise go to IDLE.
- Latency:
  - start sampled at edge E; busy=1 from E through E+NUM_BITS.
  - done=1 in the cycle after edge E+NUM_BITS.
  - Total NUM_BITS+1 cycles start-to-done.
- Arithmetic: unsigned modulo 2^NUM_BITS; carry_out is bit NUM_BITS of a+b+carry_in.
- Output registers change only on entry to DONE or on reset; they hold through IDLE and the following ADD.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on accepted start.
  - sub=1: B loaded inverted and carry register forced to 1 (carry_in ignored), giving a-b.
  - carry_out=1 means no borrow; overflow rule unchanged.
  - sub=0 identical to base behaviour.
- Not defined: no sub port; addition only.

Test Plan:
- NUM_BITS=8, a=0x3C, b=0x0F, carry_in=0, start one cycle -> busy 8 cycles, done pulse 9 cycles after start; sum=0x4B, carry_out=0, overflow=0.
- a=0xFF, b=0x01, carry_in=0 -> sum=0x00, carry_out=1, overflow=0; then a=0x7F, b=0x01 -> sum=0x80, carry_out=0, overflow=1.
- a=0x00, b=0x00, carry_in=1 -> sum=0x01, carry_out=0; start held high continuously -> back-to-back ops, done every 9 cycles, start ignored during busy.
- Start a=0xAA, b=0x55; drop n_rst low at 4th ADD cycle -> busy=0, sum=0x00 immediately, no done pulse; after release, a new start gives the correct result.
- Change a, b mid-ADD (a=0x12, b=0x34 captured, then inputs driven to 0xFF) -> sum=0x46; sum holds 0x46 through IDLE until the next done.
- With SERIAL_ADDER_SUB_EN: sub=1, a=0x05, b=0x07 -> sum=0xFE, carry_out=0; a=0x07, b=0x05 -> sum=0x02, carry_out=1.
